// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: picorv32-style native memory bus bundle.
//
// Signals:
//   valid  request strobe, held by the requester until ready
//   instr  instruction-fetch qualifier
//   addr   byte address (ADDR_WIDTH bits)
//   wdata  write data
//   wstrb  byte strobes, 0 means read
//   ready  completion pulse from the responder
//   rdata  read data, valid with ready
//
// Modports:
//   master  side that issues requests (drives valid/instr/addr/wdata/wstrb)
//   slave   side that answers requests (drives ready/rdata)
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  valid;
    logic                  instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  ready;
    logic [31:0]           rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one native memory port between two requesters.
// Requester 0 is the CPU, requester 1 a secondary master (boot loader, DMA).
// Round-robin on contention, grant held until completion, optional timeout
// that force-completes a hung transfer and raises a sticky error flag.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   m0, m1       requester buses (slave modport: arbiter answers them)
//   s            downstream bus (master modport: arbiter issues requests)
//   grant        index of the requester currently or last granted
//   bus_error    sticky timeout flag
//   error_clear  clears bus_error (a coincident timeout wins)
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    mem_bus_arbiter_if.slave        m0,
    mem_bus_arbiter_if.slave        m1,
    mem_bus_arbiter_if.master       s,
    output logic                    grant,
    output logic                    bus_error,
    input  logic                    error_clear
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state_q, state_n;
    logic                  s_valid_q, s_valid_n;
    logic                  s_instr_q, s_instr_n;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_n;
    logic [31:0]           s_wdata_q, s_wdata_n;
    logic [3:0]            s_wstrb_q, s_wstrb_n;
    logic                  m0_ready_q, m0_ready_n;
    logic                  m1_ready_q, m1_ready_n;
    logic [31:0]           m0_rdata_q, m0_rdata_n;
    logic [31:0]           m1_rdata_q, m1_rdata_n;
    logic                  grant_q, grant_n;
    logic                  err_q, err_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic [CW-1:0]         cnt_inc;
    logic                  sel;
    logic                  timeout_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            s_valid_q  <= 1'b0;
            s_instr_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            grant_q    <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_n;
            s_valid_q  <= s_valid_n;
            s_instr_q  <= s_instr_n;
            s_addr_q   <= s_addr_n;
            s_wdata_q  <= s_wdata_n;
            s_wstrb_q  <= s_wstrb_n;
            m0_ready_q <= m0_ready_n;
            m1_ready_q <= m1_ready_n;
            m0_rdata_q <= m0_rdata_n;
            m1_rdata_q <= m1_rdata_n;
            grant_q    <= grant_n;
            err_q      <= err_n;
            cnt_q      <= cnt_n;
        end
    end

    // Counter value after this BUSY cycle; the timeout fires on the edge where
    // it would reach TIMEOUT_CYCLES, i.e. after exactly TIMEOUT_CYCLES BUSY cycles.
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

    always_comb begin
        state_n    = state_q;
        s_valid_n  = s_valid_q;
        s_instr_n  = s_instr_q;
        s_addr_n   = s_addr_q;
        s_wdata_n  = s_wdata_q;
        s_wstrb_n  = s_wstrb_q;
        m0_ready_n = 1'b0;
        m1_ready_n = 1'b0;
        m0_rdata_n = m0_rdata_q;
        m1_rdata_n = m1_rdata_q;
        grant_n    = grant_q;
        err_n      = error_clear ? 1'b0 : err_q;
        cnt_n      = cnt_q;
        // Under contention the requester not granted last time wins.
        sel        = (m0.valid && m1.valid) ? ~grant_q : m1.valid;

        unique case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    grant_n   = sel;
                    s_valid_n = 1'b1;
                    s_instr_n = sel ? m1.instr : m0.instr;
                    s_addr_n  = sel ? m1.addr  : m0.addr;
                    s_wdata_n = sel ? m1.wdata : m0.wdata;
                    s_wstrb_n = sel ? m1.wstrb : m0.wstrb;
                    cnt_n     = '0;
                    state_n   = BUSY;
                end
            end
            BUSY: begin
                // Saturate rather than wrap (only reachable with the timeout disabled).
                cnt_n = (cnt_q == '1) ? cnt_q : cnt_inc;
                if (s.ready) begin
                    s_valid_n = 1'b0;
                    if (grant_q) begin
                        m1_rdata_n = s.rdata;
                        m1_ready_n = 1'b1;
                    end else begin
                        m0_rdata_n = s.rdata;
                        m0_ready_n = 1'b1;
                    end
                    state_n = RESP;
                end else if (timeout_hit) begin
                    s_valid_n = 1'b0;
                    err_n     = 1'b1;
                    if (grant_q) begin
                        m1_rdata_n = '0;
                        m1_ready_n = 1'b1;
                    end else begin
                        m0_rdata_n = '0;
                        m0_ready_n = 1'b1;
                    end
                    state_n = RESP;
                end
            end
            RESP: begin
                // Requesters are deliberately not sampled here so a valid still
                // high from the completed transfer is not granted again.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign s.valid   = s_valid_q;
    assign s.instr   = s_instr_q;
    assign s.addr    = s_addr_q;
    assign s.wdata   = s_wdata_q;
    assign s.wstrb   = s_wstrb_q;
    assign m0.ready  = m0_ready_q;
    assign m0.rdata  = m0_rdata_q;
    assign m1.ready  = m1_ready_q;
    assign m1.rdata  = m1_rdata_q;
    assign grant     = grant_q;
    assign bus_error = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter with an
// 8-cycle timeout. Expected completions are queued when a request is driven
// and popped by a monitor when a ready pulse appears.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 8;

    logic clock = 1'b0;
    logic reset;
    logic grant;
    logic bus_error;
    logic error_clear;

    mem_bus_arbiter_if #(.ADDR_WIDTH(32)) m0_if ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(32)) m1_if ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(32)) s_if ();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_WIDTH    (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .grant      (grant),
        .bus_error  (bus_error),
        .error_clear(error_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          mst;
        bit          instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          respond;
        int          wait_cyc;
        logic [31:0] rdata;
        bit          clr;
        bit          err;
    } vec_t;

    typedef struct {
        bit          mst;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, want);
        end
    endtask

    task automatic set_master(input bit mst, input bit v, input bit instr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb);
        if (mst) begin
            m1_if.valid = v; m1_if.instr = instr; m1_if.addr = addr;
            m1_if.wdata = wdata; m1_if.wstrb = wstrb;
        end else begin
            m0_if.valid = v; m0_if.instr = instr; m0_if.addr = addr;
            m0_if.wdata = wdata; m0_if.wstrb = wstrb;
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (m0_if.ready === 1'b1 || m1_if.ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready act=%b%b exp=00", m1_if.ready, m0_if.ready);
            end else begin
                e = sb.pop_front();
                chk("ready_sel", {m1_if.ready, m0_if.ready}, e.mst ? 2'b10 : 2'b01);
                chk("rdata", e.mst ? m1_if.rdata : m0_if.rdata, e.rdata);
                chk("resp_bus_error", bus_error, e.err);
            end
        end
    end

    // One request from a single master, checked cycle by cycle while BUSY.
    task automatic run_vec(input vec_t v);
        exp_t        e;
        logic [71:0] want;
        set_master(v.mst, 1'b1, v.instr, v.addr, v.wdata, v.wstrb);
        error_clear = v.clr;
        e.mst   = v.mst;
        e.rdata = v.respond ? v.rdata : 32'h0;
        e.err   = v.err;
        sb.push_back(e);
        want = {1'b1, v.instr, v.addr, v.wdata, v.wstrb, 2'b00};
        @(negedge clock);
        chk("grant", grant, v.mst);
        for (int k = 0; k < int'(TO); k++) begin
            chk("busy_payload", {s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb,
                                 m0_if.ready, m1_if.ready}, want);
            // Requester payload changes mid-transfer must not reach the bus.
            set_master(v.mst, 1'b1, ~v.instr, ~v.addr, ~v.wdata, ~v.wstrb);
            if (v.respond && k == v.wait_cyc) begin
                s_if.ready = 1'b1;
                s_if.rdata = v.rdata;
            end
            @(negedge clock);
            if (s_if.ready) break;
        end
        s_if.ready = 1'b0;
        s_if.rdata = 32'hFFFF_FFFF;
        chk("resp_svalid", s_if.valid, 1'b0);
        set_master(v.mst, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        error_clear = 1'b0;
        @(negedge clock);
        chk("idle_ready", {m0_if.ready, m1_if.ready, s_if.valid}, 3'b000);
        if (v.err) begin
            chk("err_sticky", bus_error, 1'b1);
            error_clear = 1'b1;
            @(negedge clock);
            error_clear = 1'b0;
            chk("err_cleared", bus_error, 1'b0);
        end else begin
            chk("no_err", bus_error, 1'b0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int   n;
        int   last;
        exp_t e;

        //        mst instr addr           wdata          wstrb  resp wait rdata          clr err
        vecs[0] = '{1'b0, 1'b0, 32'h3000_0034, 32'h0000_0000, 4'h0, 1'b1, 0, 32'h0000_00A5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0000_AB00, 4'h2, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b1, 2, 32'h0000_0013, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0000_0000, 4'h0, 1'b1, 1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_2000, 32'hCAFE_0001, 4'hF, 1'b1, 7, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0000_0000, 4'h0, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h4000_0004, 32'h0000_0000, 4'h0, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b1};

        reset       = 1'b1;
        error_clear = 1'b0;
        s_if.ready  = 1'b0;
        s_if.rdata  = 32'h0;
        set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clock);
        chk("reset_state", {s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb,
                            m0_if.ready, m1_if.ready, m0_if.rdata, m1_if.rdata,
                            grant, bus_error},
            {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        reset = 1'b0;

        // Continuous contention: grants alternate 0,1,0,1 at 3-cycle spacing.
        set_master(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        set_master(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h5A5A_0001;
        for (int i = 0; i < 4; i++) begin
            e.mst = (i % 2) != 0; e.rdata = 32'h5A5A_0001; e.err = 1'b0;
            sb.push_back(e);
        end
        n    = 0;
        last = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clock);
            if (m0_if.ready || m1_if.ready) begin
                n++;
                if (n == 4) begin
                    last = c;
                    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                    set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
        end
        s_if.ready = 1'b0;
        chk("rr_count", n, 4);
        chk("rr_cycles", last, 11);
        @(negedge clock);
        chk("rr_idle", {s_if.valid, m0_if.ready, m1_if.ready}, 3'b000);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while BUSY drops the transfer and restores grant=1.
        set_master(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        @(negedge clock);
        chk("pre_reset_busy", {s_if.valid, grant}, 2'b11);
        reset = 1'b1;
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clock);
        chk("reset_drop", {s_if.valid, m0_if.ready, m1_if.ready, grant}, 4'b0001);
        reset = 1'b0;
        set_master(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
        set_master(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
        e.mst = 1'b0; e.rdata = 32'h0BAD_0600; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        chk("post_reset_grant", {grant, s_if.addr}, {1'b0, 32'h0000_0600});
        s_if.ready = 1'b1;
        s_if.rdata = 32'h0BAD_0600;
        @(negedge clock);
        s_if.ready = 1'b0;
        set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clock);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one picorv32-style native memory port (valid/ready, addr, wdata, wstrb, instr) between two requesters.
- Requester 0 is the CPU. Requester 1 is a secondary master, e.g. a UART boot loader or debug/DMA engine.
- The downstream port feeds the SoC memory/peripheral decoder.
- Round-robin arbitration on contention; the grant is held until the transaction completes; a timeout terminates hung transactions with an error flag.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles s_valid stays high without s_ready before forced completion; 0 disables the timeout.
- ADDR_WIDTH, 32, address width of all ports.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  requester 0 request; held high until m0_ready
- m0_instr  in  1  requester 0 instruction-fetch qualifier
- m0_addr  in  ADDR_WIDTH  requester 0 byte address
- m0_wdata  in  32  requester 0 write data
- m0_wstrb  in  4  requester 0 byte strobes; 0 means read
- m0_ready  out  1  one-cycle completion pulse to requester 0
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid / m1_instr / m1_addr / m1_wdata / m1_wstrb / m1_ready / m1_rdata: same as m0_*, for requester 1
- s_valid  out  1  downstream request
- s_instr  out  1  downstream instruction qualifier
- s_addr  out  ADDR_WIDTH  downstream address
- s_wdata  out  32  downstream write data
- s_wstrb  out  4  downstream strobes
- s_ready  in  1  downstream completion
- s_rdata  in  32  downstream read data, valid with s_ready
- grant  out  1  index of the requester currently or last granted
- bus_error  out  1  sticky timeout flag
- error_clear  in  1  clears bus_error

Behaviour:
- Reset: state IDLE; s_valid, m0_ready, m1_ready, bus_error = 0; s_* payload, m*_rdata = 0; grant = 1, so requester 0 wins the first contention. Reset asserted mid-transaction drops the transaction at the next edge; no ready pulse is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On a sampled m0_valid or m1_valid, select a requester. If only one is valid, select it. If both are valid, select the one not equal to grant.
  - Latch the selected payload into the s_* registers, update grant, set s_valid=1, go to BUSY.
  - Requester payload is captured once; later changes are ignored until completion.
- BUSY:
  - s_valid stays 1 with a stable payload. The timeout counter increments each cycle.
  - On s_ready=1: s_valid<=0, the granted m*_rdata<=s_rdata, the granted m*_ready<=1, go to RESP.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no s_ready: s_valid<=0, m*_rdata<=0, m*_ready<=1, bus_error<=1, go to RESP.
  - s_ready arriving in the same cycle as the timeout takes precedence: normal completion, no error.
- RESP:
  - m*_ready is high for exactly this one cycle; cleared on exit; go to IDLE.
  - Requesters are not sampled in RESP, so a valid still high from the completed transfer is not re-granted.
- Latency: request sampled at edge E0; s_valid high in the cycle after E0. If s_ready is sampled at edge Ek, the master's ready is high in the cycle after Ek. Minimum sample-to-ready is 2 cycles; minimum request-to-request spacing is 3 cycles.
- Only the granted requester ever sees ready; the other requester's m*_ready stays 0.
- m*_rdata holds its last value outside ready cycles. Writes return rdata = s_rdata as sampled.
- bus_error: set on timeout; cleared by error_clear. If a timeout and error_clear coincide, set wins.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It resets to 0 on entering BUSY and never wraps.

Test Plan:
- Single m0 read, addr 0x3000_0034, s_ready 1 cycle after s_valid, s_rdata 0x0000_00A5 -> s_addr=0x3000_0034, s_wstrb=0; m0_ready one cycle with m0_rdata=0x A5; m1_ready stays 0.
- m0 and m1 both valid continuously after reset -> grants alternate 0,1,0,1 over 4 transactions; each ready is a single cycle.
- m1 byte write, wstrb=4'b0010, wdata=0x0000_AB00, slave delays s_ready 5 cycles -> s_* payload stable for all 5 cycles even if m1_addr toggles; m1_ready after completion.
- TIMEOUT_CYCLES=8, slave never responds -> s_valid drops after 8 BUSY cycles; m0_ready with rdata=0; bus_error=1 until error_clear, then 0.
- s_ready on the exact timeout cycle -> normal completion with s_rdata; bus_error stays 0.
- Reset asserted while BUSY -> next cycle s_valid=0, no ready pulse; the next contention grants m0.
